radiation_histogram_accumulator: RTL

Hardware histogram stage directly downstream of the radiation receiver. Consumes one 16-bit radiation value per `valueValid` pulse, bins it, and increments the bin count in on-chip RAM with a read-modify-write pipeline. Pulses `valueProcessingFinished` back to the receiver when each value is committed. Exposes a random-access bin readout port and status counters to the PS.

---
 rtl/radiation_histogram_accumulator.sv | 137 +++++++++++++
 1 files changed

// File: rtl/radiation_histogram_accumulator.sv
// Histogram stage: bins 16-bit radiation values into an on-chip RAM through a
// read-modify-write pipeline, with a PS readout port and status counters.
module radiation_histogram_accumulator #(
  parameter int BIN_ADDR_W = 8,
  parameter int BIN_SHIFT  = 4,
  parameter int COUNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           valueIn,
  input  logic                  valueValid,
  input  logic                  clearStart,
  input  logic [BIN_ADDR_W-1:0] readAddr,
  output logic [COUNT_W-1:0]    readData,
  output logic                  valueProcessingFinished,
  output logic                  busy,
  output logic [31:0]           totalCount,
  output logic [31:0]           overflowCount,
  output logic [31:0]           droppedCount
);

  // state  | meaning
  // IDLE   | waiting for a value, or launching a pending clear
  // READ   | port A address driven with the latched bin index
  // UPDATE | bin written with saturating rdata+1 (overflow: count only)
  // DONE   | finish pulse presented to the receiver
  // CLEAR  | one bin zeroed per cycle, counters zeroed on the last bin

  localparam int NUM_BINS = 1 << BIN_ADDR_W;

  typedef enum logic [2:0] {IDLE, READ, UPDATE, DONE, CLEAR} state_t;

  state_t                  state;
  logic                    clear_pending;
  logic [BIN_ADDR_W-1:0]   bin_idx;
  logic [BIN_ADDR_W-1:0]   clear_addr;
  logic                    ovf;

  logic [COUNT_W-1:0]      mem [NUM_BINS];
  logic [COUNT_W-1:0]      rdata_a;
  logic                    we_a;
  logic [BIN_ADDR_W-1:0]   addr_a;
  logic [COUNT_W-1:0]      wdata_a;

  logic [15:0]             idx_full;
  logic                    in_ovf;

  assign idx_full = valueIn >> BIN_SHIFT;
  assign in_ovf   = (idx_full >> BIN_ADDR_W) != 16'd0;
  assign busy     = (state != IDLE) || clear_pending;

  always_comb begin
    we_a    = 1'b0;
    addr_a  = bin_idx;
    wdata_a = '0;
    case (state)
      UPDATE: begin
        we_a    = !ovf;
        // a full counter is rewritten with its own value, i.e. it sticks
        wdata_a = (&rdata_a) ? rdata_a : rdata_a + 1'b1;
      end
      CLEAR: begin
        we_a    = 1'b1;
        addr_a  = clear_addr;
      end
      default: ;
    endcase
  end

  // Read-first on both ports: nonblocking write leaves old data on the reads.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    rdata_a  <= mem[addr_a];
    readData <= mem[readAddr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                   <= IDLE;
      clear_pending           <= 1'b1;
      clear_addr              <= '0;
      bin_idx                 <= '0;
      ovf                     <= 1'b0;
      valueProcessingFinished <= 1'b0;
      totalCount              <= '0;
      overflowCount           <= '0;
      droppedCount            <= '0;
    end else begin
      valueProcessingFinished <= 1'b0;

      if (valueValid && state != IDLE && !(&droppedCount))
        droppedCount <= droppedCount + 32'd1;

      case (state)
        IDLE: begin
          if (clear_pending) begin
            state      <= CLEAR;
            clear_addr <= '0;
          end else if (clearStart) begin
            clear_pending <= 1'b1;
          end else if (valueValid) begin
            bin_idx    <= idx_full[BIN_ADDR_W-1:0];
            ovf        <= in_ovf;
            totalCount <= totalCount + 32'd1;
            state      <= READ;
          end
        end
        READ: begin
          if (clearStart) clear_pending <= 1'b1;
          state <= UPDATE;
        end
        UPDATE: begin
          if (clearStart) clear_pending <= 1'b1;
          if (ovf) overflowCount <= overflowCount + 32'd1;
          valueProcessingFinished <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (clearStart) clear_pending <= 1'b1;
          state <= IDLE;
        end
        CLEAR: begin
          clear_addr <= clear_addr + 1'b1;
          if (&clear_addr) begin
            totalCount    <= '0;
            overflowCount <= '0;
            droppedCount  <= '0;
            clear_pending <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
